memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: the clock port is named clk and the reset port is named reset.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_read_memory  in  1  load request from the memory stage.
- mem_write_memory  in  1  store request from the memory stage.
- vector_op_memory  in  1  1 = 128-bit vector access, 0 = 16-bit scalar access.
- address_memory  in  16  word address of the scalar word or of vector lane 0.
- store_data_memory  in  16  scalar store data.
- store_vector_memory  in  128  vector store data.
- ram_address  out  16  data RAM address.
- ram_wren  out  1  data RAM write enable.
- ram_wdata  out  16  data RAM write data.
- ram_rdata  in  16  data RAM read data; synchronous, valid 1 cycle after the address.
- data_from_memory_in  out  16  scalar load result, to the memory/writeback register.
- vector_data_from_memory_in  out  128  vector load result, to the memory/writeback register.
- stall_pipeline  out  1  freezes every upstream pipeline stage and the memory/writeback register.
REQ-003 Parameters (name, default, meaning):
- LANES, 8, number of vector lanes.
- LANE_W, 16, lane width in bits.

Function
REQ-004 States SHALL be IDLE, S_READ, V_READ, V_WRITE and V_DONE.
REQ-005 Definitions:
- Cycle 0 is the first cycle in IDLE with mem_read_memory=1 or mem_write_memory=1.
- The request inputs are held stable while stall_pipeline=1.
REQ-006 If mem_read_memory and mem_write_memory are both 1, the access SHALL be a write and the read SHALL be ignored.
REQ-007 Scalar write (IDLE): in cycle 0, ram_address=address_memory, ram_wren=1, ram_wdata=store_data_memory, stall_pipeline=0; state stays IDLE.
REQ-008 Scalar read:
- Cycle 0: ram_address=address_memory, stall_pipeline=1; next state S_READ.
- Cycle 1 (S_READ): ram_rdata is captured into the scalar hold register, data_from_memory_in=ram_rdata (combinational pass-through), stall_pipeline=0; next state IDLE.
REQ-009 Vector read (V_READ):
- Cycles 0..7: ram_address=base+k, where k is the beat counter.
- The word returned in cycle k+1 SHALL be written into lane k, bits [16k+15:16k].
- stall_pipeline=1 in cycles 0..8; after the lane-7 capture the state SHALL be V_DONE.
REQ-010 V_DONE (cycle 9): vector_data_from_memory_in holds the full vector, stall_pipeline=0; next state IDLE.
REQ-011 Vector write (V_WRITE):
- Cycles 0..7: ram_address=base+k, ram_wren=1, ram_wdata=lane k of store_vector_memory.
- stall_pipeline=1 in cycles 0..6 and 0 in cycle 7; return to IDLE after beat 7.
REQ-012 Address arithmetic SHALL be 16-bit modulo, so base 16'hFFFE addresses FFFE, FFFF, 0000 .. 0005.
REQ-013 Beat counter SHALL be 3 bits, cleared on entry to V_READ and V_WRITE.
REQ-014 Requests SHALL be sampled only in IDLE and ignored in every other state.
REQ-015 data_from_memory_in SHALL hold the last scalar load value outside S_READ.
REQ-016 vector_data_from_memory_in SHALL hold the last completed vector and SHALL update only at the lane-7 capture.
REQ-017 ram_wren SHALL be 0 in IDLE with no write request, and in S_READ, V_READ and V_DONE.

Reset
REQ-018 When reset=1, the block SHALL immediately (asynchronously):
- set the state to IDLE and the beat counter to 0;
- clear both hold registers to zero;
- drive ram_wren=0 and stall_pipeline=0.
REQ-019 Reset asserted mid-operation SHALL abandon the transfer with no further RAM writes and no partial vector output; lanes already captured SHALL be cleared.

Structure
REQ-020 A shared package SHALL hold:
- the state enum;
- LANES, LANE_W, and VEC_W = 128.
REQ-021 One sub-module, vector_lane_buffer, SHALL hold the 128-bit vector register with a 3-bit lane index, a lane write enable and asynchronous clear.

Verification
REQ-022 Scalar write addr 0x0010, data 0xBEEF -> ram_wren=1 for 1 cycle, stall_pipeline never 1, and a later read of 0x0010 returns 0xBEEF.
REQ-023 Scalar read of 0x0020 holding 0x1234 -> stall_pipeline=1 for exactly 1 cycle, data_from_memory_in=0x1234 in cycle 1.
REQ-024 Vector write base 0x0100, lanes 0x0000..0x0007 -> 8 consecutive writes to 0x0100..0x0107, stall_pipeline=1 for 7 cycles; then a vector read -> stall_pipeline=1 for 9 cycles and output 128'h0007_0006_..._0000 in cycle 9.
REQ-025 Vector read at base 0xFFFE -> addresses FFFE, FFFF, 0000..0005 in order.
REQ-026 mem_read_memory=1 and mem_write_memory=1 together -> a write occurs and the read hold register is unchanged.
REQ-027 Reset asserted in V_WRITE beat 3 -> ram_wren=0 in the same cycle, state IDLE, vector output 0, and no further writes.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared types and sizing for the memory access unit: FSM state encoding
// and vector geometry.
package memory_access_unit_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 16;
  localparam int VEC_W  = 128;

  typedef enum logic [2:0] {
    IDLE,
    S_READ,
    V_READ,
    V_WRITE,
    V_DONE
  } state_t;

endpackage

// File: rtl/memory_access_unit_vector_lane_buffer.sv
// Vector load assembly register: lanes are written one at a time, and the
// visible vector is refreshed only when the last lane lands.
module vector_lane_buffer #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       lane_we,
  input  logic [$clog2(LANES)-1:0]   lane_idx,
  input  logic [LANE_W-1:0]          lane_data,
  output logic [LANES*LANE_W-1:0]    vec_q
);
  import memory_access_unit_pkg::*;

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  logic [LANES*LANE_W-1:0] stage;
  logic [LANES*LANE_W-1:0] merged;

  always_comb begin
    merged = stage;
    merged[lane_idx*LANE_W +: LANE_W] = lane_data;
  end

  // Partial lanes live in stage; vec_q only ever shows a complete vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
      vec_q <= '0;
    end else if (lane_we) begin
      stage <= merged;
      if (lane_idx == LAST_LANE) vec_q <= merged;
    end
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-stage access sequencer: scalar loads/stores in one RAM beat,
// vector loads/stores as LANES consecutive beats with pipeline stall.
module memory_access_unit #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read_memory,
  input  logic                      mem_write_memory,
  input  logic                      vector_op_memory,
  input  logic [15:0]               address_memory,
  input  logic [LANE_W-1:0]         store_data_memory,
  input  logic [LANES*LANE_W-1:0]   store_vector_memory,
  output logic [15:0]               ram_address,
  output logic                      ram_wren,
  output logic [LANE_W-1:0]         ram_wdata,
  input  logic [LANE_W-1:0]         ram_rdata,
  output logic [LANE_W-1:0]         data_from_memory_in,
  output logic [LANES*LANE_W-1:0]   vector_data_from_memory_in,
  output logic                      stall_pipeline
);
  import memory_access_unit_pkg::*;

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(LANES - 1);
  localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(LANES - 2);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt, beat_ahead;
  logic [15:0]        addr_ahead;
  logic [LANE_W-1:0]  scalar_hold;
  logic               wren_c, stall_c, lane_we;

  // Beat 0 is issued from IDLE, so the counter trails the issued beat by one.
  assign beat_ahead = beat_cnt + 1'b1;
  assign addr_ahead = address_memory + 16'(beat_ahead);

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    ram_address  = address_memory;
    ram_wdata    = store_data_memory;
    wren_c       = 1'b0;
    stall_c      = 1'b0;
    lane_we      = 1'b0;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (mem_write_memory) begin
          wren_c = 1'b1;
          if (vector_op_memory) begin
            ram_wdata = store_vector_memory[LANE_W-1:0];
            stall_c   = 1'b1;
            state_nxt = V_WRITE;
          end
        end else if (mem_read_memory) begin
          stall_c   = 1'b1;
          state_nxt = vector_op_memory ? V_READ : S_READ;
        end
      end
      S_READ: state_nxt = IDLE;
      V_READ: begin
        stall_c     = 1'b1;
        ram_address = addr_ahead;
        lane_we     = 1'b1;
        if (beat_cnt == LAST_RD) state_nxt = V_DONE;
        else                     beat_cnt_nxt = beat_ahead;
      end
      V_DONE: state_nxt = IDLE;
      V_WRITE: begin
        ram_address = addr_ahead;
        ram_wdata   = store_vector_memory[beat_ahead*LANE_W +: LANE_W];
        wren_c      = 1'b1;
        if (beat_cnt == LAST_WR) begin
          state_nxt = IDLE;
        end else begin
          stall_c      = 1'b1;
          beat_cnt_nxt = beat_ahead;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must silence the RAM and release the pipeline within the same cycle.
  assign ram_wren       = wren_c & ~reset;
  assign stall_pipeline = stall_c & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      scalar_hold <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (state == S_READ) scalar_hold <= ram_rdata;
    end
  end

  assign data_from_memory_in = (state == S_READ) ? ram_rdata : scalar_hold;

  vector_lane_buffer #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_buffer (
    .clk       (clk),
    .reset     (reset),
    .lane_we   (lane_we),
    .lane_idx  (beat_cnt),
    .lane_data (ram_rdata),
    .vec_q     (vector_data_from_memory_in)
  );

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: transaction-level model producing per-cycle
// expectations, a behavioural RAM, directed cases and randomized traffic.
module tb_memory_access_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read_memory, mem_write_memory, vector_op_memory;
  logic [15:0]  address_memory, store_data_memory;
  logic [127:0] store_vector_memory;
  logic [15:0]  ram_address, ram_wdata, ram_rdata;
  logic         ram_wren;
  logic [15:0]  data_from_memory_in;
  logic [127:0] vector_data_from_memory_in;
  logic         stall_pipeline;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .clk                        (clk),
    .reset                      (reset),
    .mem_read_memory            (mem_read_memory),
    .mem_write_memory           (mem_write_memory),
    .vector_op_memory           (vector_op_memory),
    .address_memory             (address_memory),
    .store_data_memory          (store_data_memory),
    .store_vector_memory        (store_vector_memory),
    .ram_address                (ram_address),
    .ram_wren                   (ram_wren),
    .ram_wdata                  (ram_wdata),
    .ram_rdata                  (ram_rdata),
    .data_from_memory_in        (data_from_memory_in),
    .vector_data_from_memory_in (vector_data_from_memory_in),
    .stall_pipeline             (stall_pipeline)
  );

  typedef struct {
    bit           rd;
    bit           wr;
    bit           vec;
    logic [15:0]  addr;
    logic [15:0]  sdata;
    logic [127:0] vdata;
  } in_t;

  typedef struct {
    bit           chk_addr;
    logic [15:0]  addr;
    logic         wren;
    logic [15:0]  wdata;
    logic         stall;
    logic [15:0]  sout;
    logic [127:0] vout;
  } rec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0;
  int n_stall = 0;
  logic [15:0]  exp_scalar;
  logic [127:0] exp_vec;
  bit [15:0]    ref_mem [bit [15:0]];
  bit [15:0]    env_mem [bit [15:0]];
  logic [15:0]  last_addrs [$];

  localparam logic [127:0] VLIT = 128'h0007_0006_0005_0004_0003_0002_0001_0000;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Synchronous-read data RAM seen by the DUT (old data on read-during-write).
  always @(posedge clk) begin : env_ram
    logic [15:0] rd_word;
    rd_word = env_mem.exists(ram_address) ? env_mem[ram_address] : init_val(ram_address);
    if (ram_wren === 1'b1) env_mem[ram_address] = ram_wdata;
    ram_rdata <= rd_word;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input bit rd, input bit wr, input bit vec, input logic [15:0] a,
                             input logic [15:0] sd, input logic [127:0] vd);
    in_t t;
    t.rd = rd; t.wr = wr; t.vec = vec; t.addr = a; t.sdata = sd; t.vdata = vd;
    return t;
  endfunction

  function automatic in_t no_req();
    return mk(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.chk_addr = 1'b0; r.addr = '0; r.wren = 1'b0; r.wdata = '0; r.stall = 1'b0;
    r.sout = exp_scalar; r.vout = exp_vec;
    return r;
  endfunction

  task automatic drive(input in_t t);
    mem_read_memory     = t.rd;
    mem_write_memory    = t.wr;
    vector_op_memory    = t.vec;
    address_memory      = t.addr;
    store_data_memory   = t.sdata;
    store_vector_memory = t.vdata;
  endtask

  // One clock cycle: apply inputs after the edge, compare on the falling edge.
  task automatic play(input in_t t, input rec_t r);
    @(posedge clk);
    #1;
    drive(t);
    @(negedge clk);
    if (ram_wren === 1'b1) n_wr++;
    if (stall_pipeline === 1'b1) n_stall++;
    if (r.chk_addr) check("ram_address", 128'(ram_address), 128'(r.addr));
    check("ram_wren", 128'(ram_wren), 128'(r.wren));
    if (r.wren) check("ram_wdata", 128'(ram_wdata), 128'(r.wdata));
    check("stall_pipeline", 128'(stall_pipeline), 128'(r.stall));
    check("data_from_memory_in", 128'(data_from_memory_in), 128'(r.sout));
    check("vector_data_from_memory_in", vector_data_from_memory_in, r.vout);
  endtask

  // Builds the expected cycle-by-cycle behaviour of one request from the
  // access rules, plays it (optionally cut short), then updates the model.
  task automatic run_txn(input in_t t, input int abort_at);
    rec_t         recs[$];
    rec_t         r;
    logic [127:0] nv;
    int           played;
    nv = '0;
    last_addrs.delete();
    if (t.wr && !t.vec) begin
      r = idle_rec(); r.chk_addr = 1'b1; r.addr = t.addr; r.wren = 1'b1; r.wdata = t.sdata;
      recs.push_back(r);
    end else if (t.wr) begin
      for (int k = 0; k < 8; k++) begin
        r = idle_rec(); r.chk_addr = 1'b1; r.addr = t.addr + 16'(k); r.wren = 1'b1;
        r.wdata = t.vdata[16*k +: 16]; r.stall = (k < 7);
        recs.push_back(r);
      end
    end else if (t.rd && !t.vec) begin
      r = idle_rec(); r.chk_addr = 1'b1; r.addr = t.addr; r.stall = 1'b1;
      recs.push_back(r);
      r = idle_rec(); r.sout = ref_rd(t.addr);
      recs.push_back(r);
    end else if (t.rd) begin
      for (int k = 0; k < 8; k++) nv[16*k +: 16] = ref_rd(t.addr + 16'(k));
      for (int k = 0; k < 10; k++) begin
        r = idle_rec(); r.chk_addr = (k < 8); r.addr = t.addr + 16'(k);
        r.stall = (k <= 8); r.vout = (k == 9) ? nv : exp_vec;
        recs.push_back(r);
      end
    end
    played = 0;
    foreach (recs[i]) begin
      if (abort_at >= 0 && i >= abort_at) break;
      play(t, recs[i]);
      played++;
      if (recs[i].chk_addr) last_addrs.push_back(recs[i].addr);
      if (recs[i].wren) ref_mem[recs[i].addr] = recs[i].wdata;
    end
    if (played == recs.size() && !t.wr && t.rd) begin
      if (t.vec) exp_vec = nv;
      else       exp_scalar = ref_rd(t.addr);
    end
  endtask

  initial begin
    int   w0, s0;
    in_t  t;
    reset      = 1'b1;
    exp_scalar = '0;
    exp_vec    = '0;
    drive(no_req());
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_wren", 128'(ram_wren), 128'(1'b0));
    check("reset_stall", 128'(stall_pipeline), 128'(1'b0));
    check("reset_scalar", 128'(data_from_memory_in), 128'(16'h0000));
    check("reset_vector", vector_data_from_memory_in, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) play(no_req(), idle_rec());

    // Scalar store then load-back.
    w0 = n_wr; s0 = n_stall;
    run_txn(mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, '0), -1);
    check("req022_write_cycles", 128'(n_wr - w0), 128'(1));
    check("req022_stall_cycles", 128'(n_stall - s0), 128'(0));
    play(no_req(), idle_rec());
    run_txn(mk(1'b1, 1'b0, 1'b0, 16'h0010, '0, '0), -1);
    check("req022_readback", 128'(data_from_memory_in), 128'(16'hBEEF));

    // Scalar load of preloaded word.
    s0 = n_stall;
    run_txn(mk(1'b1, 1'b0, 1'b0, 16'h0020, '0, '0), -1);
    check("req023_stall_cycles", 128'(n_stall - s0), 128'(1));
    check("req023_data", 128'(data_from_memory_in), 128'(16'h1234));

    // Simultaneous read and write behaves as a write.
    w0 = n_wr;
    run_txn(mk(1'b1, 1'b1, 1'b0, 16'h0030, 16'h7777, '0), -1);
    check("req026_write_cycles", 128'(n_wr - w0), 128'(1));
    play(no_req(), idle_rec());
    check("req026_hold_unchanged", 128'(data_from_memory_in), 128'(16'h1234));
    run_txn(mk(1'b1, 1'b0, 1'b0, 16'h0030, '0, '0), -1);
    check("req026_readback", 128'(data_from_memory_in), 128'(16'h7777));

    // Vector store and load-back.
    w0 = n_wr; s0 = n_stall;
    run_txn(mk(1'b0, 1'b1, 1'b1, 16'h0100, '0, VLIT), -1);
    check("req024_write_cycles", 128'(n_wr - w0), 128'(8));
    check("req024_write_stall", 128'(n_stall - s0), 128'(7));
    play(no_req(), idle_rec());
    s0 = n_stall;
    run_txn(mk(1'b1, 1'b0, 1'b1, 16'h0100, '0, '0), -1);
    check("req024_read_stall", 128'(n_stall - s0), 128'(9));
    check("req024_vector", vector_data_from_memory_in, VLIT);

    // Address wrap at the top of memory.
    run_txn(mk(1'b1, 1'b0, 1'b1, 16'hFFFE, '0, '0), -1);
    check("req025_addr0", 128'(last_addrs[0]), 128'(16'hFFFE));
    check("req025_addr1", 128'(last_addrs[1]), 128'(16'hFFFF));
    check("req025_addr2", 128'(last_addrs[2]), 128'(16'h0000));
    check("req025_addr7", 128'(last_addrs[7]), 128'(16'h0005));

    // Reset during beat 3 of a vector store.
    t = mk(1'b0, 1'b1, 1'b1, 16'h0200, '0,
           128'hC007_C006_C005_C004_C003_C002_C001_C000);
    run_txn(t, 3);
    w0 = n_wr;
    @(posedge clk);
    #1;
    drive(t);
    #1;
    reset = 1'b1;
    #1;
    check("req027_wren", 128'(ram_wren), 128'(1'b0));
    check("req027_stall", 128'(stall_pipeline), 128'(1'b0));
    check("req027_vector", vector_data_from_memory_in, 128'h0);
    check("req027_scalar", 128'(data_from_memory_in), 128'(16'h0000));
    drive(no_req());
    exp_scalar = '0;
    exp_vec    = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) play(no_req(), idle_rec());
    check("req027_no_more_writes", 128'(n_wr - w0), 128'(0));
    run_txn(mk(1'b1, 1'b0, 1'b1, 16'h0200, '0, '0), -1);
    check("req027_lane2_written", 128'(vector_data_from_memory_in[47:32]), 128'(16'hC002));
    check("req027_lane3_untouched", 128'(vector_data_from_memory_in[63:48]), 128'(16'hA7C0));

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      t.rd    = 1'($urandom_range(0, 1));
      t.wr    = 1'($urandom_range(0, 1));
      t.vec   = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                             : 16'($urandom_range(0, 47));
      t.sdata = 16'($urandom);
      t.vdata = {$urandom, $urandom, $urandom, $urandom};
      if (t.rd || t.wr) run_txn(t, -1);
      else              play(t, idle_rec());
      repeat ($urandom_range(0, 2)) play(no_req(), idle_rec());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
